kyber_hpm_host_seq: RTL

//  Host-side initiator for the KyberHPM4PE_top accelerator port. Accepts opcodes from a

---
 rtl/kyber_hpm_host_seq_if.sv | 51 +++++
 rtl/kyber_hpm_host_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_hpm_host_seq_if.sv
// Host/accelerator bundle for kyber_hpm_host_seq: command, host data in/out, accelerator
// strobes and data, plus status. master = the sequencer, slave = the surrounding fabric.
interface kyber_hpm_host_seq_if #(
    parameter int unsigned PE_NUMBER = 4
);
    localparam int unsigned W = 12 * PE_NUMBER;

    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         hpm_load_a_f;
    logic         hpm_load_a_i;
    logic         hpm_load_b_f;
    logic         hpm_load_b_i;
    logic         hpm_read_a;
    logic         hpm_read_b;
    logic         hpm_start_ab;
    logic         hpm_start_fntt;
    logic         hpm_start_pwm2;
    logic         hpm_start_intt;
    logic [W-1:0] hpm_din;
    logic [W-1:0] hpm_dout;
    logic         hpm_done;
    logic         busy;
    logic         op_done;
    logic         err;

    modport master (
        input  cmd_valid, cmd_op, in_data, in_valid, out_ready, hpm_dout, hpm_done,
        output cmd_ready, in_ready, out_data, out_valid,
        output hpm_load_a_f, hpm_load_a_i, hpm_load_b_f, hpm_load_b_i,
        output hpm_read_a, hpm_read_b,
        output hpm_start_ab, hpm_start_fntt, hpm_start_pwm2, hpm_start_intt,
        output hpm_din, busy, op_done, err
    );

    modport slave (
        output cmd_valid, cmd_op, in_data, in_valid, out_ready, hpm_dout, hpm_done,
        input  cmd_ready, in_ready, out_data, out_valid,
        input  hpm_load_a_f, hpm_load_a_i, hpm_load_b_f, hpm_load_b_i,
        input  hpm_read_a, hpm_read_b,
        input  hpm_start_ab, hpm_start_fntt, hpm_start_pwm2, hpm_start_intt,
        input  hpm_din, busy, op_done, err
    );
endinterface

// File: rtl/kyber_hpm_host_seq.sv
// Host-side sequencer for the KyberHPM accelerator port: stages host words in a local RAM,
// issues load/read/start pulses, waits for completion and drains captured results.
module kyber_hpm_host_seq #(
    parameter int unsigned PE_NUMBER = 4,
    parameter int unsigned N_COEFF   = 256,
    parameter int unsigned READ_LAT  = 3,
    parameter int unsigned TIMEOUT   = 4095
) (
    input logic                  clk,
    input logic                  reset,
    kyber_hpm_host_seq_if.master bus
);
    localparam int unsigned W     = 12 * PE_NUMBER;
    localparam int unsigned WORDS = N_COEFF / PE_NUMBER;
    localparam int unsigned AddrW = $clog2(WORDS);
    localparam int unsigned CntW  = AddrW + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StFill, StLoad, StStart, StWait, StCapt, StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [CntW-1:0]   wcnt_q, wcnt_d;
    logic [CntW-1:0]   rcnt_q, rcnt_d;
    logic [CntW-1:0]   rcnt_inc;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic [3:0]        load_q, load_d;
    logic [1:0]        read_q, read_d;
    logic [3:0]        start_q, start_d;
    logic [W-1:0]      hpm_din_q, hpm_din_d;
    logic              busy_q, busy_d;
    logic              op_done_q, op_done_d;
    logic              err_q, err_d;

    logic [W-1:0]      ram [WORDS];
    logic              ram_we;
    logic [AddrW-1:0]  ram_waddr;
    logic [W-1:0]      ram_wdata;

    assign rcnt_inc = rcnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        tcnt_d      = tcnt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        op_done_d   = 1'b0;
        load_d      = '0;
        read_d      = '0;
        start_d     = '0;
        hpm_din_d   = '0;
        ram_we      = 1'b0;
        ram_waddr   = wcnt_q[AddrW-1:0];
        ram_wdata   = bus.in_data;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d   = bus.cmd_op[1:0];
                    err_d  = 1'b0;
                    wcnt_d = '0;
                    rcnt_d = '0;
                    tcnt_d = '0;
                    case (bus.cmd_op)
                        4'd0, 4'd1, 4'd2, 4'd3: state_d = StFill;
                        4'd4: begin read_d  = 2'b01;   state_d = StCapt;  end
                        4'd5: begin read_d  = 2'b10;   state_d = StCapt;  end
                        4'd6: begin start_d = 4'b0001; state_d = StStart; end
                        4'd7: begin start_d = 4'b0010; state_d = StStart; end
                        4'd8: begin start_d = 4'b0100; state_d = StStart; end
                        4'd9: begin start_d = 4'b1000; state_d = StStart; end
                        default: begin
                            err_d     = 1'b1;
                            op_done_d = 1'b1;
                        end
                    endcase
                end
            end
            StFill: begin
                if (bus.in_valid && in_ready_q) begin
                    ram_we = 1'b1;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == CntW'(WORDS - 1)) begin
                        state_d = StLoad;
                        rcnt_d  = '0;
                        load_d  = 4'b0001 << op_q;
                    end
                end
            end
            StLoad: begin
                // Each cycle prefetches the next word so hpm_din streams without gaps;
                // the extra counter bit marks the tail cycle after the last word.
                if (rcnt_q == CntW'(WORDS)) begin
                    op_done_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    hpm_din_d = ram[rcnt_q[AddrW-1:0]];
                    rcnt_d    = rcnt_inc;
                end
            end
            StStart: begin
                tcnt_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                if (bus.hpm_done) begin
                    op_done_d = 1'b1;
                    state_d   = StIdle;
                end else if (tcnt_q == TW'(TIMEOUT)) begin
                    err_d     = 1'b1;
                    op_done_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StCapt: begin
                // tcnt counts the read latency, then holds while words stream in.
                if (tcnt_q != TW'(READ_LAT)) begin
                    tcnt_d = tcnt_q + 1'b1;
                end else begin
                    ram_we    = 1'b1;
                    ram_wdata = bus.hpm_dout;
                    wcnt_d    = wcnt_q + 1'b1;
                    if (wcnt_q == CntW'(WORDS - 1)) begin
                        state_d     = StDrain;
                        rcnt_d      = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = ram[0];
                    end
                end
            end
            StDrain: begin
                if (out_valid_q && bus.out_ready) begin
                    if (rcnt_q == CntW'(WORDS - 1)) begin
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        op_done_d   = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        rcnt_d     = rcnt_inc;
                        out_data_d = ram[rcnt_inc[AddrW-1:0]];
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        cmd_ready_d = (state_d == StIdle);
        in_ready_d  = (state_d == StFill);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            tcnt_q      <= '0;
            cmd_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            load_q      <= '0;
            read_q      <= '0;
            start_q     <= '0;
            hpm_din_q   <= '0;
            busy_q      <= 1'b0;
            op_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            tcnt_q      <= tcnt_d;
            cmd_ready_q <= cmd_ready_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            load_q      <= load_d;
            read_q      <= read_d;
            start_q     <= start_d;
            hpm_din_q   <= hpm_din_d;
            busy_q      <= busy_d;
            op_done_q   <= op_done_d;
            err_q       <= err_d;
        end
    end

    // Staging RAM carries no reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.hpm_load_a_f   = load_q[0];
    assign bus.hpm_load_a_i   = load_q[1];
    assign bus.hpm_load_b_f   = load_q[2];
    assign bus.hpm_load_b_i   = load_q[3];
    assign bus.hpm_read_a     = read_q[0];
    assign bus.hpm_read_b     = read_q[1];
    assign bus.hpm_start_ab   = start_q[0];
    assign bus.hpm_start_fntt = start_q[1];
    assign bus.hpm_start_pwm2 = start_q[2];
    assign bus.hpm_start_intt = start_q[3];
    assign bus.hpm_din        = hpm_din_q;
    assign bus.busy           = busy_q;
    assign bus.op_done        = op_done_q;
    assign bus.err            = err_q;
endmodule
